// File: rtl/rgb_pattern_source.sv
// AXI-Stream RGB test-pattern source: solid, ramp, checkerboard and index patterns, N frames per run.
// Optional build macro RGB_SRC_STALL_EN inserts LFSR-driven bubbles between beats; the pixel order is unchanged.
module rgb_pattern_source #(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 16,
  parameter int V_ACTIVE   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              pattern_sel,
  input  logic [3*DATA_WIDTH-1:0] solid_rgb,
  input  logic [7:0]              num_frames,
  output logic                    busy,
  output logic                    done,
  output logic [3*DATA_WIDTH-1:0] m_tdata_rgb,
  output logic                    m_tvalid_rgb,
  input  logic                    m_tready_rgb,
  output logic                    m_tlast_rgb,
  output logic                    m_tuser_rgb
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [XW-1:0]           x_q, nx;
  logic [YW-1:0]           y_q, ny;
  logic [7:0]              frame_q, nframe;
  logic [1:0]              pat_q;
  logic [3*DATA_WIDTH-1:0] solid_q;
  logic [7:0]              nfr_q;
  logic                    accept, xfer, last_beat, load_ok;

  function automatic logic [3*DATA_WIDTH-1:0] pix(input logic [1:0] sel,
                                                  input logic [3*DATA_WIDTH-1:0] solid,
                                                  input logic [XW-1:0] px,
                                                  input logic [YW-1:0] py);
    logic [31:0]           xe, ye, s, p;
    logic [DATA_WIDTH-1:0] ones;
    xe   = 32'(px);
    ye   = 32'(py);
    s    = xe + ye;
    p    = ye * 32'(H_ACTIVE) + xe;
    ones = '1;
    case (sel)
      2'd0:    pix = solid;
      2'd1:    pix = {xe[DATA_WIDTH-1:0], ye[DATA_WIDTH-1:0], s[DATA_WIDTH-1:0]};
      2'd2:    pix = (xe[3] ^ ye[3]) ? {3{ones}} : '0;
      default: pix = {3{p[DATA_WIDTH-1:0]}};
    endcase
  endfunction

`ifdef RGB_SRC_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci form, taps 16,14,13,11; free-runs only while a run is active.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (state_q == RUN) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign load_ok = lfsr_q[0];
`else
  assign load_ok = 1'b1;
`endif

  assign accept = (state_q == IDLE) && start && !done;
  assign xfer   = m_tvalid_rgb && m_tready_rgb;

  always_comb begin
    nx        = x_q + XW'(1);
    ny        = y_q;
    nframe    = frame_q;
    last_beat = 1'b0;
    if (x_q == XW'(H_ACTIVE - 1)) begin
      nx = '0;
      ny = y_q + YW'(1);
      if (y_q == YW'(V_ACTIVE - 1)) begin
        ny     = '0;
        nframe = frame_q + 8'd1;
        last_beat = (frame_q == nfr_q - 8'd1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (xfer && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters name the beat currently presented (or waiting for a bubble to clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      frame_q      <= '0;
      pat_q        <= '0;
      solid_q      <= '0;
      nfr_q        <= 8'd1;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_tvalid_rgb <= 1'b0;
      m_tdata_rgb  <= '0;
      m_tlast_rgb  <= 1'b0;
      m_tuser_rgb  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        pat_q        <= pattern_sel;
        solid_q      <= solid_rgb;
        nfr_q        <= (num_frames == 8'd0) ? 8'd1 : num_frames;
        x_q          <= '0;
        y_q          <= '0;
        frame_q      <= '0;
        busy         <= 1'b1;
        m_tvalid_rgb <= load_ok;
        m_tdata_rgb  <= pix(pattern_sel, solid_rgb, '0, '0);
        m_tlast_rgb  <= 1'b0;
        m_tuser_rgb  <= 1'b1;
      end else if (state_q == RUN) begin
        if (xfer) begin
          if (last_beat) begin
            busy         <= 1'b0;
            done         <= 1'b1;
            m_tvalid_rgb <= 1'b0;
          end else begin
            x_q          <= nx;
            y_q          <= ny;
            frame_q      <= nframe;
            m_tvalid_rgb <= load_ok;
            m_tdata_rgb  <= pix(pat_q, solid_q, nx, ny);
            m_tlast_rgb  <= (nx == XW'(H_ACTIVE - 1));
            m_tuser_rgb  <= (nx == '0) && (ny == '0);
          end
        end else if (!m_tvalid_rgb && load_ok) begin
          m_tvalid_rgb <= 1'b1;
          m_tdata_rgb  <= pix(pat_q, solid_q, x_q, y_q);
          m_tlast_rgb  <= (x_q == XW'(H_ACTIVE - 1));
          m_tuser_rgb  <= (x_q == '0) && (y_q == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_pattern_source.sv
// Scoreboard bench for rgb_pattern_source: expected beats are queued per run and popped on each transfer.
module tb_rgb_pattern_source;
  localparam int DW = 8;
  localparam int H  = 16;
  localparam int V  = 8;

  logic          clk = 1'b0;
  logic          rst, start, m_tready_rgb;
  logic [1:0]    pattern_sel;
  logic [3*DW-1:0] solid_rgb, m_tdata_rgb;
  logic [7:0]    num_frames;
  logic          busy, done, m_tvalid_rgb, m_tlast_rgb, m_tuser_rgb;

  rgb_pattern_source #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .num_frames(num_frames), .busy(busy), .done(done),
    .m_tdata_rgb(m_tdata_rgb), .m_tvalid_rgb(m_tvalid_rgb), .m_tready_rgb(m_tready_rgb),
    .m_tlast_rgb(m_tlast_rgb), .m_tuser_rgb(m_tuser_rgb)
  );

  always #5 clk = ~clk;

  int   checks = 0, errors = 0;
  int   cyc = 0, beats = 0, busy_cnt = 0, done_cnt = 0, last_xfer = -10;
  bit   toggle_rdy = 1'b0;
  logic [25:0] expq[$];
  logic        prev_hold = 1'b0;
  logic [26:0] prev_snap = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input logic [1:0] sel, input logic [23:0] solid,
                                          input int x, input int y);
    int s, p;
    s = x + y;
    p = y * H + x;
    case (sel)
      2'd0:    return solid;
      2'd1:    return {x[7:0], y[7:0], s[7:0]};
      2'd2:    return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: return {p[7:0], p[7:0], p[7:0]};
    endcase
  endfunction

  always @(posedge clk) cyc++;
  always @(posedge clk) if (toggle_rdy) #1 m_tready_rgb = ~m_tready_rgb;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check("hold", {m_tvalid_rgb, m_tdata_rgb, m_tlast_rgb, m_tuser_rgb}, prev_snap);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        check("done_timing", cyc, last_xfer + 1);
      end
      if (m_tvalid_rgb && m_tready_rgb) begin
        beats++;
        last_xfer = cyc;
        check("beat_expected", expq.size() > 0, 1);
        if (expq.size() > 0)
          check("beat", {m_tdata_rgb, m_tlast_rgb, m_tuser_rgb}, expq.pop_front());
      end
      prev_hold = m_tvalid_rgb && !m_tready_rgb;
      prev_snap = {m_tvalid_rgb, m_tdata_rgb, m_tlast_rgb, m_tuser_rgb};
    end
  end

  task automatic push_run(input logic [1:0] sel, input logic [23:0] solid, input int nf);
    int n;
    n = (nf == 0) ? 1 : nf;
    for (int f = 0; f < n; f++)
      for (int y = 0; y < V; y++)
        for (int x = 0; x < H; x++)
          expq.push_back({exp_pix(sel, solid, x, y), x == H - 1, (x == 0) && (y == 0)});
  endtask

  // Configuration inputs are scrambled right after the start edge to show they are latched.
  task automatic pulse_start(input logic [1:0] sel, input logic [23:0] solid, input logic [7:0] nf);
    @(posedge clk); #1;
    start = 1'b1; pattern_sel = sel; solid_rgb = solid; num_frames = nf;
    @(posedge clk); #1;
    start = 1'b0; pattern_sel = ~sel; solid_rgb = ~solid; num_frames = 8'd3;
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
`ifndef RGB_SRC_STALL_EN
    check("first_valid_user", {m_tvalid_rgb, m_tuser_rgb}, 2'b11);
`endif
  endtask

  task automatic wait_done(input int limit);
    int d0, i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < limit) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_low_after", busy, 1'b0);
    check("queue_drained", expq.size(), 0);
  endtask

  task automatic wait_beats(input int target, input int limit);
    int i;
    i = 0;
    while (beats < target && i < limit) begin
      @(posedge clk);
      i++;
    end
    check("beats_reached", beats >= target, 1);
  endtask

  initial begin
    int b0, d0;
    rst = 1'b1; start = 1'b1; m_tready_rgb = 1'b1;
    pattern_sel = 2'd0; solid_rgb = '0; num_frames = 8'd1;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, m_tvalid_rgb, m_tdata_rgb, m_tlast_rgb, m_tuser_rgb}, '0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_after_reset", {busy, done, m_tvalid_rgb}, 3'b000);
    check("no_beats_idle", beats, 0);

    // Solid colour, one frame, ready held high.
    push_run(2'd0, 24'h19C8AF, 1);
    b0 = beats;
    busy_cnt = 0;
    pulse_start(2'd0, 24'h19C8AF, 8'd1);
    wait_done(4000);
    check("solid_beats", beats - b0, 128);
`ifndef RGB_SRC_STALL_EN
    check("solid_busy_cycles", busy_cnt, 128);
`endif

    // Ramp with ready toggling every cycle.
    push_run(2'd1, 24'h0, 1);
    b0 = beats;
    toggle_rdy = 1'b1;
    pulse_start(2'd1, 24'h123456, 8'd1);
    wait_done(4000);
    check("ramp_beats", beats - b0, 128);
    toggle_rdy = 1'b0;
    @(posedge clk); #2;
    m_tready_rgb = 1'b1;

    // Checkerboard, two frames back to back.
    push_run(2'd2, 24'h0, 2);
    b0 = beats;
    pulse_start(2'd2, 24'h0, 8'd2);
    wait_done(4000);
    check("checker_beats", beats - b0, 256);

    // Index pattern, num_frames = 0 behaves as one frame.
    push_run(2'd3, 24'h0, 0);
    b0 = beats;
    pulse_start(2'd3, 24'h0, 8'd0);
    wait_done(4000);
    check("index_beats", beats - b0, 128);

    // Mid-run start is ignored; reset abandons the run with no done.
    push_run(2'd1, 24'h0, 1);
    b0 = beats;
    d0 = done_cnt;
    pulse_start(2'd1, 24'h0, 8'd1);
    wait_beats(b0 + 20, 2000);
    @(posedge clk); #1;
    start = 1'b1; pattern_sel = 2'd0; solid_rgb = 24'hABCDEF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_beats(b0 + 40, 2000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_midrun_outputs", {busy, done, m_tvalid_rgb, m_tlast_rgb, m_tuser_rgb}, 5'b0);
    expq.delete();
    repeat (5) @(posedge clk);
    check("rst_midrun_no_done", done_cnt - d0, 0);

    push_run(2'd3, 24'h0, 1);
    b0 = beats;
    pulse_start(2'd3, 24'h0, 8'd1);
    wait_done(4000);
    check("after_rst_beats", beats - b0, 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
